// File: rtl/bram_port_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter and its round-robin pick.
package bram_port_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_port_arb_rr_pick.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_pick
    import bram_port_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);

    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bram_port_arb.sv
// Round-robin sharing of one BRAM port between NREQ requesters.
// Define BRAM_PORT_ARB_INIT_EN to zero the RAM after reset before serving.
module bram_port_arb
    import bram_port_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ADR  = 8,
    parameter int DAT  = 9,
    parameter int DEP  = 256,
    parameter int DEL  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_wen,
    input  logic [NREQ*ADR-1:0] req_adr,
    input  logic [NREQ*DAT-1:0] req_wda,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvld,
    output logic [DAT-1:0]      rdat,
    output logic                ready,
    output logic [ADR-1:0]      ram_adr,
    output logic                ram_wen,
    output logic                ram_ren,
    output logic [DAT-1:0]      ram_wda,
    input  logic [DAT-1:0]      ram_rda
);

    localparam int IW = clog2(NREQ);

    if (DEP > (1 << ADR) || DEL < 1 || DEL > 2 ||
        NREQ < 2 || NREQ > 16) begin : g_param_chk
        $error("bram_port_arb: parameter out of range");
    end

    logic            ready_q, ready_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [ADR-1:0]  adr_q, adr_d;
    logic [DAT-1:0]  wda_q, wda_d;
    logic            wen_q, wen_d;
    logic            ren_q, ren_d;
    logic            push;
    logic            tv_q  [DEL+1];
    logic [IW-1:0]   tid_q [DEL+1];

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_id;
    logic            run;

`ifdef BRAM_PORT_ARB_INIT_EN
    localparam logic [ADR-1:0] LAST = ADR'(DEP - 1);
    state_e          state_q, state_d;
    logic [ADR-1:0]  swp_q, swp_d;
`endif

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    assign run = rst_n && ready_q;

    always_comb begin
        gnt   = run ? pick_gnt : '0;
        ptr_d = ptr_q;
        adr_d = adr_q;
        wda_d = wda_q;
        wen_d = 1'b0;
        ren_d = 1'b0;
        push  = 1'b0;
`ifdef BRAM_PORT_ARB_INIT_EN
        state_d = state_q;
        swp_d   = swp_q;
        ready_d = (state_q == ST_RUN);
        if (state_q == ST_INIT) begin
            adr_d = swp_q;
            wda_d = '0;
            wen_d = 1'b1;
            ren_d = 1'b1;
            swp_d = swp_q + 1'b1;
            if (swp_q == LAST) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
`else
        ready_d = 1'b1;
`endif
        if (|gnt) begin
            adr_d = req_adr[int'(pick_id)*ADR +: ADR];
            wda_d = req_wda[int'(pick_id)*DAT +: DAT];
            wen_d = req_wen[pick_id];
            ren_d = 1'b1;
            push  = !req_wen[pick_id];
            if (pick_id == IW'(NREQ - 1)) ptr_d = '0;
            else                           ptr_d = pick_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            ptr_q   <= '0;
            adr_q   <= '0;
            wda_q   <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            for (int k = 0; k <= DEL; k++) begin
                tv_q[k]  <= 1'b0;
                tid_q[k] <= '0;
            end
`ifdef BRAM_PORT_ARB_INIT_EN
            state_q <= ST_INIT;
            swp_q   <= '0;
`endif
        end else begin
            ready_q  <= ready_d;
            ptr_q    <= ptr_d;
            adr_q    <= adr_d;
            wda_q    <= wda_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            tv_q[0]  <= push;
            tid_q[0] <= pick_id;
            for (int k = 1; k <= DEL; k++) begin
                tv_q[k]  <= tv_q[k-1];
                tid_q[k] <= tid_q[k-1];
            end
`ifdef BRAM_PORT_ARB_INIT_EN
            state_q <= state_d;
            swp_q   <= swp_d;
`endif
        end
    end

    // Last tracker stage lines up with the RAM's read data
    always_comb begin
        rvld = '0;
        if (rst_n && tv_q[DEL]) rvld[tid_q[DEL]] = 1'b1;
    end

    assign rdat    = ram_rda;
    assign ready   = ready_q;
    assign ram_adr = adr_q;
    assign ram_wda = wda_q;
    assign ram_wen = wen_q;
    assign ram_ren = ren_q;

endmodule
